fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_queue_ptr.sv | 31 +++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions: instruction width, canonical NOP and the
// fetch-queue entry record used by fetch_queue.
package riscv_pkg;

    localparam int          ILEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Widest PC the entry record carries; narrower XLEN builds use the low bits.
    localparam int          PC_MAX_W  = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [ILEN-1:0]     instr;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// fq_ptr: wrap-around pointer modulo DEPTH (DEPTH a power of two) with a
// synchronous clear; used for the head, fill and tail pointers of fetch_queue.
module fq_ptr #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_r;

    // Pointer register: clear wins over increment; wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch queue. Issues sequential fetches,
// collects in-order memory responses and hands entries to decode. A redirect
// flushes the queue and discards responses still in flight for the old path.
// Optional build macro: FETCH_BYPASS_EN -- present the head entry's response
// to decode in the same cycle it arrives when nothing older is waiting.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int             XLEN     = 64,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Drops can pile up across back-to-back redirects, so give headroom.
    localparam int DW = PW + 4;

    logic [XLEN-1:0] fetch_pc_r;
    fetch_entry_t    entries_r [DEPTH];
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   inflight_r;
    logic [DW-1:0]   drop_r;

    logic [PW-1:0]   head_ptr_s;
    logic [PW-1:0]   fill_ptr_s;
    logic [PW-1:0]   tail_ptr_s;
    fetch_entry_t    head_entry_s;
    logic            issue_s;
    logic            fill_en_s;
    logic            fill_write_s;
    logic            drop_en_s;
    logic            bypass_s;
    logic            out_valid_s;
    logic            pop_s;
    logic [DW-1:0]   drop_sum_s;

    fq_ptr #(.DEPTH(DEPTH)) u_head (
        .clk(clk), .rst(rst), .clr(redirect_valid), .inc(pop_s),     .ptr(head_ptr_s)
    );
    fq_ptr #(.DEPTH(DEPTH)) u_fill (
        .clk(clk), .rst(rst), .clr(redirect_valid), .inc(fill_en_s), .ptr(fill_ptr_s)
    );
    fq_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk(clk), .rst(rst), .clr(redirect_valid), .inc(issue_s),   .ptr(tail_ptr_s)
    );

    // Per-cycle control: redirect suppresses issue, fill and pop; allocation
    // is judged before this cycle's pop.
    always_comb begin
        head_entry_s = entries_r[head_ptr_s];
        issue_s      = rst && !redirect_valid && (count_r < CW'(DEPTH));
        fill_en_s    = rst && !redirect_valid && imem_rvalid && (drop_r == '0);
        drop_en_s    = rst && !redirect_valid && imem_rvalid && (drop_r != '0);
`ifdef FETCH_BYPASS_EN
        bypass_s     = fill_en_s && (count_r != '0) && (fill_ptr_s == head_ptr_s)
                       && !head_entry_s.filled;
`else
        bypass_s     = 1'b0;
`endif
        out_valid_s  = rst && (count_r != '0) && (head_entry_s.filled || bypass_s);
        pop_s        = out_valid_s && out_ready && !redirect_valid;
        // A bypassed entry popped this cycle never needs to be stored.
        fill_write_s = fill_en_s && !(bypass_s && pop_s);
        // Responses already owed for the old path, minus one arriving now.
        drop_sum_s   = drop_r + DW'(inflight_r);
        if (imem_rvalid && (drop_sum_s != '0)) begin
            drop_sum_s = drop_sum_s - DW'(1);
        end else begin
            drop_sum_s = drop_sum_s;
        end
    end

    assign imem_req  = issue_s;
    assign imem_addr = rst ? fetch_pc_r : '0;
    assign out_valid = out_valid_s;
    assign out_pc    = rst ? head_entry_s.pc[XLEN-1:0] : '0;
    assign out_instr = !rst ? 32'h0000_0000 : (bypass_s ? imem_rdata : head_entry_s.instr);

    // Fetch address: restart on reset, jump on redirect, step by one word per issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
        end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(4);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Occupancy, outstanding-request and drop counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r    <= '0;
            inflight_r <= '0;
            drop_r     <= '0;
        end else if (redirect_valid) begin
            count_r    <= '0;
            inflight_r <= '0;
            drop_r     <= drop_sum_s;
        end else begin
            count_r    <= count_r + CW'(issue_s) - CW'(pop_s);
            inflight_r <= inflight_r + CW'(issue_s) - CW'(fill_en_s);
            drop_r     <= drop_en_s ? (drop_r - DW'(1)) : drop_r;
        end
    end

    // Entry storage: pop clears, fill captures the word, issue allocates.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                entries_r[i] <= '0;
            end else if (redirect_valid) begin
                entries_r[i].filled <= 1'b0;
            end else begin
                if (pop_s && (head_ptr_s == PW'(i))) begin
                    entries_r[i].filled <= 1'b0;
                end
                if (fill_write_s && (fill_ptr_s == PW'(i))) begin
                    entries_r[i].instr  <= imem_rdata;
                    entries_r[i].filled <= 1'b1;
                end
                if (issue_s && (tail_ptr_s == PW'(i))) begin
                    entries_r[i].pc     <= PC_MAX_W'(fetch_pc_r);
                    entries_r[i].filled <= 1'b0;
                end
            end
        end
    end

endmodule
